dcache_resp: RTL
================

Name: dcache_resp

Overview:
- Data-side responder for the load/store request interface driven by the decode stage. It receives req_valid/wen/wdata/addr/wlen.
- Holds a small direct-mapped, write-through, no-write-allocate cache of 64-bit words.
- Refills misses and posts stores over a simple valid/ready memory bus.
- Returns load data right-aligned and zero-extended. Sign extension happens downstream.
- Stalls the pipeline via stall_o while a miss or store is in flight.

Parameters:
- LINES, 16, number of one-word (8-byte) lines; power of 2, at least 2.
- IDX_W, $clog2(LINES), index width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- req_valid_i  in  1  request present (already cleared by decode on hazard/exception).
- req_wen_i  in  1  1 = store, 0 = load.
- req_wdata_i  in  64  store data, right-aligned, upper bits zero.
- req_addr_i  in  64  byte address.
- req_wlen_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- stall_o  out  1  request not accepted this cycle; the requester holds all req_* stable.
- resp_valid_o  out  1  load data valid; pulses one cycle after the load is accepted.
- resp_rdata_o  out  64  load data, lane shifted to bit 0, zero-extended above the size.
- mem_req_valid_o  out  1  memory request.
- mem_req_ready_i  in  1  memory accepts the request (handshake = valid & ready).
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  64  req_addr_i with bits [2:0] forced to 0.
- mem_wdata_o  out  64  store data shifted left by 8*addr[2:0].
- mem_wstrb_o  out  8  byte enables: ((1<<(1<<wlen))-1) << addr[2:0].
- mem_rvalid_i  in  1  read data return (one beat per read).
- mem_rdata_i  in  64  read data.

Behaviour:
- Address split: offset = addr[2:0]; index = addr[3+IDX_W-1:3]; tag = addr[63:3+IDX_W].
- Storage: valid[LINES], tag[LINES], data[LINES] held in flops. Hit = valid[index] & tag match, evaluated combinationally from req_addr_i.
- Alignment: addr is trusted as naturally aligned because decode filters misalignment. If it is not aligned, the low offset bits inside the size are ignored: offset is masked to a multiple of the size.
- FSM states are IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_DONE.
- IDLE, no request: stall_o = 0; memory bus idle.
- IDLE, load hit:
  - stall_o = 0; the request is accepted.
  - Next cycle: resp_valid_o = 1 and resp_rdata_o = (data[index] >> 8*offset) masked to the size.
- IDLE, load miss: stall_o = 1 combinationally; next state is RD_REQ.
- IDLE, store: stall_o = 1; next state is WR_REQ. This applies to hit and miss alike.
- RD_REQ:
  - stall_o = 1; mem_req_valid_o = 1; mem_we_o = 0.
  - On handshake, go to RD_WAIT.
  - Address and control are held from req_* (the requester keeps them stable).
- RD_WAIT:
  - stall_o = 1.
  - On mem_rvalid_i: write data[index] = mem_rdata_i, tag[index] = tag, valid[index] = 1, then go to IDLE.
  - The held request then hits the following cycle. Load miss latency = handshake + return + 2 cycles to resp_valid_o.
  - If mem_rvalid_i arrives in the same cycle as the handshake, it is ignored. Data is only accepted in RD_WAIT.
- WR_REQ:
  - stall_o = 1; mem_req_valid_o = 1; mem_we_o = 1; wdata/wstrb as defined under Ports.
  - On handshake: if hit, merge the strobed bytes into data[index]. If miss, the cache is unchanged (no allocate).
  - Then go to WR_DONE.
- WR_DONE:
  - stall_o = 0, so the store is accepted this cycle. No resp_valid_o; no memory request.
  - Go to IDLE unconditionally. The store is not re-issued.
- mem_req_valid_o, once raised, stays high with stable address, data and strobe until the handshake.
- resp_valid_o is never asserted for stores. It is asserted for exactly one cycle per accepted load.
- If req_valid_i drops in IDLE while stall_o is high (requester flush), the FSM still leaves IDLE only when req_valid_i was high in that cycle. Once out of IDLE the transaction completes regardless of req_valid_i. A refill still writes the line using the latched index and tag: the FSM latches index, tag, offset and wlen on leaving IDLE.
- Reset (asynchronous, any state):
  - FSM goes to IDLE; all valid bits clear.
  - stall_o = 0, resp_valid_o = 0, resp_rdata_o = 0, mem_req_valid_o = 0, mem_we_o = 0, mem_addr_o / mem_wdata_o / mem_wstrb_o = 0.
  - Tag and data contents need not be reset.
  - A memory response arriving after reset is ignored.

Test Plan:
- After reset, load double at 0x80000010 with mem returning 0x1122334455667788:
  - stall_o = 1 through the refill; mem_addr_o = 0x80000010.
  - Then hit: resp_valid_o one cycle later with resp_rdata_o = 0x1122334455667788.
- Load byte at 0x80000013, same line: no stall; next cycle resp_rdata_o = 0x55. Load half at 0x80000016 → 0x1122.
- Store word 0xDEADBEEF at 0x80000014 (hit):
  - mem_wstrb_o = 0xF0; mem_wdata_o = 0xDEADBEEF00000000.
  - WR_DONE lasts one cycle.
  - A following load double at 0x80000010 hits and returns 0xDEADBEEF55667788.
- Store byte 0xAB to 0x80000101 (miss): exactly one write handshake with wstrb = 0x02. A later load of 0x80000101 misses (no allocate).
- Conflict: load 0x80000010, then load 0x80000090 (same index with LINES = 16, different tag) → second is a miss and refills. Reloading 0x80000010 misses again.
- Hold mem_req_ready_i low for 5 cycles during RD_REQ: mem_req_valid_o and mem_addr_o stay stable. Assert rst mid-RD_WAIT: all outputs go to 0, and a late mem_rvalid_i is ignored. The next load to the same address misses.

Source files
------------

// File: rtl/dcache_resp.sv
// Data-side load/store responder: direct-mapped, write-through, no-write-allocate cache of
// 64-bit words, refilling misses and posting stores over a valid/ready memory bus.
module dcache_resp #(
    parameter int unsigned LINES = 16,
    parameter int unsigned IDX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_wen_i,
    input  logic [63:0] req_wdata_i,
    input  logic [63:0] req_addr_i,
    input  logic [1:0]  req_wlen_i,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic [63:0] resp_rdata_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_wstrb_o,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i
);

    localparam int unsigned TAG_W = 61 - IDX_W;

    typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StWrDone} state_e;

    state_e state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [63:0]      data_mem [LINES];

    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [2:0]       off_q;
    logic [1:0]       wlen_q;
    logic [63:0]      wdata_q;

    logic        resp_valid_q;
    logic [63:0] resp_rdata_q;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       req_off;
    logic             req_hit;
    logic             lat_hit;
    logic             load_acc;
    logic             latch_en;
    logic             refill;
    logic             wr_merge;
    logic [7:0]       strb;
    logic [63:0]      wdata_sh;
    logic [63:0]      load_data;

    function automatic logic [7:0] size_mask(input logic [1:0] wlen);
        case (wlen)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Misaligned offsets are rounded down to a multiple of the access size.
    function automatic logic [2:0] align_off(input logic [2:0] off, input logic [1:0] wlen);
        case (wlen)
            2'd0:    return off;
            2'd1:    return {off[2:1], 1'b0};
            2'd2:    return {off[2], 2'b00};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [63:0] extract(input logic [63:0] word, input logic [2:0] off,
                                            input logic [1:0] wlen);
        logic [63:0] sh;
        sh = word >> {off, 3'b000};
        case (wlen)
            2'd0:    return {56'd0, sh[7:0]};
            2'd1:    return {48'd0, sh[15:0]};
            2'd2:    return {32'd0, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    assign req_idx   = req_addr_i[3 +: IDX_W];
    assign req_tag   = req_addr_i[63 -: TAG_W];
    assign req_off   = align_off(req_addr_i[2:0], req_wlen_i);
    assign req_hit   = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign lat_hit   = valid_q[idx_q] && (tag_mem[idx_q] == tag_q);
    assign load_data = extract(data_mem[req_idx], req_off, req_wlen_i);
    assign strb      = size_mask(wlen_q) << off_q;
    assign wdata_sh  = wdata_q << {off_q, 3'b000};

    always_comb begin
        state_d         = state_q;
        stall_o         = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_we_o        = 1'b0;
        load_acc        = 1'b0;
        latch_en        = 1'b0;
        refill          = 1'b0;
        wr_merge        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (req_wen_i) begin
                        stall_o  = 1'b1;
                        latch_en = 1'b1;
                        state_d  = StWrReq;
                    end else if (req_hit) begin
                        load_acc = 1'b1;
                    end else begin
                        stall_o  = 1'b1;
                        latch_en = 1'b1;
                        state_d  = StRdReq;
                    end
                end
            end
            StRdReq: begin
                stall_o         = 1'b1;
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) state_d = StRdWait;
            end
            StRdWait: begin
                stall_o = 1'b1;
                if (mem_rvalid_i) begin
                    refill  = 1'b1;
                    state_d = StIdle;
                end
            end
            StWrReq: begin
                stall_o         = 1'b1;
                mem_req_valid_o = 1'b1;
                mem_we_o        = 1'b1;
                if (mem_req_ready_i) begin
                    wr_merge = lat_hit;
                    state_d  = StWrDone;
                end
            end
            StWrDone: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        mem_addr_o  = mem_req_valid_o ? {tag_q, idx_q, 3'b000} : 64'd0;
        mem_wdata_o = mem_we_o ? wdata_sh : 64'd0;
        mem_wstrb_o = mem_we_o ? strb : 8'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            idx_q        <= '0;
            tag_q        <= '0;
            off_q        <= '0;
            wlen_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= load_acc;
            if (load_acc) resp_rdata_q <= load_data;
            if (refill) valid_q[idx_q] <= 1'b1;
            // Latch the request so a flushed requester cannot disturb the bus or the refill.
            if (latch_en) begin
                idx_q   <= req_idx;
                tag_q   <= req_tag;
                off_q   <= req_off;
                wlen_q  <= req_wlen_i;
                wdata_q <= req_wdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (refill) begin
            tag_mem[idx_q]  <= tag_q;
            data_mem[idx_q] <= mem_rdata_i;
        end else if (wr_merge) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) data_mem[idx_q][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule
